acc_post_proc: RTL and testbench
================================

// Module: acc_post_proc
// PURPOSE
//  Downstream stage of the CNN accumulator. It captures each finished accumulator result
//  (accumulator oEN strobe + oDATA), then adds a per-channel bias, applies ReLU, and
//  requantizes the result with a rounded arithmetic right shift and saturation to OL bits.
//  Results are buffered in a small FIFO and handed to the feature-map writer over valid/ready.
// PARAMETERS
//  IL     10  accumulator result width, signed two's complement (matches accumulator OL)
//  BL     10  bias width, signed; BL <= IL
//  OL     8   output width, unsigned (post-ReLU)
//  SW     4   shift-amount width
//  DEPTH  4   FIFO entries, power of two, >= 2
// PORTS
//  iCLK    in   1       clock
//  iRSTn   in   1       asynchronous active-low reset
//  iCLR    in   1       synchronous flush: pipeline, FIFO, sticky flag
//  iEN     in   1       result strobe from accumulator oEN; one cycle per result
//  iDATA   in   IL      accumulator result, signed
//  iBIAS   in   BL      bias, signed; sampled with iEN
//  iSHIFT  in   SW      right-shift amount; sampled with iEN
//  oVALID  out  1       FIFO head valid
//  iREADY  in   1       consumer ready; a pop happens when oVALID && iREADY
//  oDATA   out  OL      FIFO head data
//  oFULL   out  1       FIFO holds DEPTH entries
//  oOVF    out  1       sticky: a result was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (async, iRSTn=0): all pipeline valids = 0; FIFO pointers/count = 0;
//   oVALID = 0, oDATA = 0, oFULL = 0, oOVF = 0.
//  S1 (edge after iEN=1):
//   - sum = sext(iDATA, IL+1) + sext(iBIAS, IL+1); the IL+1-bit sum cannot overflow.
//   - iSHIFT is registered alongside sum.
//  S2 (next edge):
//   - r = (sum < 0) ? 0 : sum.
//   - If shift > 0: r = (r + (1 << (shift-1))) >>> shift (round half up). Carry out of the
//     rounding add is kept (one extra bit).
//   - Saturate: r > 2^OL-1 -> 2^OL-1.
//  FIFO write: on the edge after S2 is valid. iEN at cycle t -> oVALID = 1 from cycle t+3
//   when the FIFO was empty. There is no bypass.
//  Back-to-back iEN on consecutive cycles is legal; the pipeline runs at full rate.
//  FIFO:
//   - Show-ahead; oDATA is the head entry, registered, valid whenever oVALID = 1.
//   - Write when full is accepted only if a pop happens in the same cycle. Otherwise the
//     result is dropped and oOVF is set (stays set until iCLR or reset).
//   - Simultaneous push and pop when not empty: count unchanged, order kept.
//   - Pop when empty: ignored. Pointers wrap modulo DEPTH.
//   - oFULL = (count == DEPTH); oVALID = (count != 0).
//   - oDATA holds its last value when the FIFO is empty.
//  iCLR = 1:
//   - Next edge: S1/S2 valids = 0, count = 0, oVALID = 0, oOVF = 0.
//   - iEN in the same cycle is discarded.
//   - iCLR has priority over push and pop.
//  Reset mid-operation: all in-flight and buffered results are lost with no output strobe.
// STRUCTURE
//  Shared package: IL/OL/BL defaults (consistent with the accumulator), fifo_count width
//   function clog2(DEPTH)+1.
//  Sub-module: sync_fifo (DEPTH, OL width, show-ahead, full/empty/count). The requantize
//   datapath stays inline in acc_post_proc.
// TESTING
//  1 iDATA=100, iBIAS=20, iSHIFT=2, iEN 1 cycle -> oVALID rises 3 cycles later,
//    oDATA=30 (122>>2).
//  2 iDATA=-50, iBIAS=10, iSHIFT=0 -> oDATA=0 (ReLU).
//    iDATA=6, iBIAS=0, iSHIFT=2 -> oDATA=2 (1.5 rounds up).
//  3 iDATA=511, iBIAS=511, iSHIFT=0 -> oDATA=255 (saturation); oOVF stays 0.
//  4 iREADY=0, 5 back-to-back strobes with iDATA=1..5, iBIAS=0, iSHIFT=0 -> oFULL=1,
//    oOVF=1; then iREADY=1 -> pops 1,2,3,4, oVALID=0, oFULL=0.
//  5 FIFO full while the consumer pops every cycle and iEN strobes every cycle -> no drops,
//    oOVF=0, outputs in order.
//  6 iCLR while 2 entries are buffered and 1 is in flight -> oVALID=0 next cycle, oOVF=0,
//    nothing emitted later. Repeat with an async iRSTn pulse mid-stream -> every output at
//    its reset value.

Source files
------------

// File: rtl/acc_post_proc_pkg.sv
// Shared widths for the accumulator post-processing stage and its output FIFO.
// Defaults match the accumulator result width.
package acc_post_proc_pkg;

  localparam int IL_DEF    = 10;
  localparam int BL_DEF    = 10;
  localparam int OL_DEF    = 8;
  localparam int SW_DEF    = 4;
  localparam int DEPTH_DEF = 4;

  // Occupancy counter width: must represent 0..DEPTH inclusive.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with a registered head word and synchronous flush.
// Head updates on the same edge as push/pop, so there is no bypass path.
module sync_fifo
  import acc_post_proc_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = OL_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         head_vld,
  output logic         full,
  output logic         drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = fifo_cnt_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic [CW-1:0] cnt;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign rd_nxt  = rd_ptr + AW'(1);
  assign do_pop  = pop && !empty && !clr;
  // A full FIFO still takes a write when the head leaves on the same edge.
  assign do_push = push && !clr && (!full || do_pop);
  assign drop    = push && !clr && full && !do_pop;

  assign head_vld = !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      head_dat <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_nxt;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      // Head is the next stored word, else the incoming word, else it holds.
      if (do_pop) begin
        if (cnt > CW'(1)) begin
          head_dat <= mem[rd_nxt];
        end else if (do_push) begin
          head_dat <= push_dat;
        end
      end else if (empty && do_push) begin
        head_dat <= push_dat;
      end
    end
  end

endmodule

// File: rtl/acc_post_proc.sv
// Bias add, ReLU, rounded right shift and saturation of accumulator results, buffered in a FIFO.
// Two pipeline stages plus FIFO write: a strobe at cycle t is visible at cycle t+3 when empty.
module acc_post_proc
  import acc_post_proc_pkg::*;
#(
  parameter int IL    = IL_DEF,
  parameter int BL    = BL_DEF,
  parameter int OL    = OL_DEF,
  parameter int SW    = SW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          iCLR,
  input  logic          iEN,
  input  logic [IL-1:0] iDATA,
  input  logic [BL-1:0] iBIAS,
  input  logic [SW-1:0] iSHIFT,
  output logic          oVALID,
  input  logic          iREADY,
  output logic [OL-1:0] oDATA,
  output logic          oFULL,
  output logic          oOVF
);

  // One bit of headroom over IL+1 keeps the rounding carry.
  localparam int RW = IL + 2;
  localparam logic [RW-1:0] MAXV = RW'((1 << OL) - 1);

  logic signed [IL:0] sum_d;
  logic signed [IL:0] s1_sum;
  logic [SW-1:0]      s1_shift;
  logic               s1_vld;

  logic [RW-1:0]      relu;
  logic [RW-1:0]      rnd;
  logic [RW-1:0]      rnd_sum;
  logic [RW-1:0]      shifted;
  logic [OL-1:0]      sat;

  logic [OL-1:0]      s2_dat;
  logic               s2_vld;
  logic               drop;

  assign sum_d = $signed({iDATA[IL-1], iDATA})
               + $signed({{(IL + 1 - BL){iBIAS[BL-1]}}, iBIAS});

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      s1_vld   <= 1'b0;
      s1_sum   <= '0;
      s1_shift <= '0;
    end else if (iCLR) begin
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= iEN;
      if (iEN) begin
        s1_sum   <= sum_d;
        s1_shift <= iSHIFT;
      end
    end
  end

  // Shifts wider than RW push the rounding constant out entirely; the result is 0 either way.
  always_comb begin
    relu    = s1_sum[IL] ? '0 : {1'b0, s1_sum};
    rnd     = (s1_shift == '0) ? '0 : (RW'(1) << (s1_shift - SW'(1)));
    rnd_sum = relu + rnd;
    shifted = rnd_sum >> s1_shift;
    sat     = (shifted > MAXV) ? '1 : shifted[OL-1:0];
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      s2_vld <= 1'b0;
      s2_dat <= '0;
    end else if (iCLR) begin
      s2_vld <= 1'b0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_dat <= sat;
      end
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (OL)
  ) u_fifo (
    .clk      (iCLK),
    .rst_n    (iRSTn),
    .clr      (iCLR),
    .push     (s2_vld),
    .push_dat (s2_dat),
    .pop      (iREADY),
    .head_dat (oDATA),
    .head_vld (oVALID),
    .full     (oFULL),
    .drop     (drop)
  );

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      oOVF <= 1'b0;
    end else if (iCLR) begin
      oOVF <= 1'b0;
    end else if (drop) begin
      oOVF <= 1'b1;
    end
  end

endmodule

// File: tb/tb_acc_post_proc.sv
// Randomised and directed bench for acc_post_proc with a queue-based reference model.
module tb_acc_post_proc;

  localparam int DEPTH = 4;

  logic       iCLK;
  logic       iRSTn;
  logic       iCLR;
  logic       iEN;
  logic [9:0] iDATA;
  logic [9:0] iBIAS;
  logic [3:0] iSHIFT;
  logic       oVALID;
  logic       iREADY;
  logic [7:0] oDATA;
  logic       oFULL;
  logic       oOVF;

  acc_post_proc #(
    .IL(10), .BL(10), .OL(8), .SW(4), .DEPTH(DEPTH)
  ) dut (
    .iCLK   (iCLK),
    .iRSTn  (iRSTn),
    .iCLR   (iCLR),
    .iEN    (iEN),
    .iDATA  (iDATA),
    .iBIAS  (iBIAS),
    .iSHIFT (iSHIFT),
    .oVALID (oVALID),
    .iREADY (iREADY),
    .oDATA  (oDATA),
    .oFULL  (oFULL),
    .oOVF   (oOVF)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Plain-arithmetic reference: bias, ReLU, round half up, saturate to 8 bits.
  function automatic int ref_val(input int d, input int b, input int s);
    int r;
    r = d + b;
    if (r < 0) r = 0;
    if (s > 0) r = (r + (1 << (s - 1))) >> s;
    if (r > 255) r = 255;
    return r;
  endfunction

  // Model: two-cycle delay line into a bounded queue of expected outputs.
  int  sb[$];
  int  occ;
  bit  m_ovf;
  bit  p1, p2;
  int  p1_v, p2_v;

  always @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn || iCLR) begin
      p1 = 0; p2 = 0; occ = 0; m_ovf = 0;
      sb.delete();
    end else begin
      if (iREADY && occ > 0) occ--;
      if (p2) begin
        if (occ < DEPTH) begin
          occ++;
          sb.push_back(p2_v);
        end else begin
          m_ovf = 1;
        end
      end
      p2   = p1;
      p2_v = p1_v;
      p1   = iEN;
      p1_v = ref_val(int'($signed(iDATA)), int'($signed(iBIAS)), int'(iSHIFT));
    end
  end

  // Monitor: flags and head compared every cycle; a pop consumes the expected entry.
  always @(negedge iCLK) begin
    if (iRSTn) begin
      check("valid", int'(oVALID), int'(occ != 0));
      check("full",  int'(oFULL),  int'(occ == DEPTH));
      check("ovf",   int'(oOVF),   int'(m_ovf));
      if (oVALID) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          check("data", int'(oDATA), sb[0]);
          if (iREADY) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic cyc();
    @(posedge iCLK);
    #1;
  endtask

  task automatic drive(input bit en, input int d, input int b, input int s);
    iEN    = en;
    iDATA  = 10'(d);
    iBIAS  = 10'(b);
    iSHIFT = 4'(s);
    cyc();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, int'(oVALID), 0);
    check({tag, "_data"},  int'(oDATA),  0);
    check({tag, "_full"},  int'(oFULL),  0);
    check({tag, "_ovf"},   int'(oOVF),   0);
  endtask

  initial begin
    iRSTn = 1'b0; iCLR = 1'b0; iEN = 1'b0; iREADY = 1'b1;
    iDATA = '0; iBIAS = '0; iSHIFT = '0;
    #12;
    check_reset_outputs("reset");
    #1 iRSTn = 1'b1;
    cyc();

    // Basic value, ReLU, rounding, saturation.
    drive(1, 100, 20, 2);
    idle(5);
    drive(1, -50, 10, 0);
    drive(1, 6, 0, 2);
    idle(5);
    drive(1, 511, 511, 0);
    idle(5);

    // Overflow with consumer stalled, then drain.
    iREADY = 1'b0;
    for (int i = 1; i <= 5; i++) drive(1, i, 0, 0);
    idle(4);
    iREADY = 1'b1;
    idle(8);
    iCLR = 1'b1; cyc(); iCLR = 1'b0;
    idle(2);

    // Full FIFO with pop every cycle and strobe every cycle: no drops.
    iREADY = 1'b0;
    for (int i = 0; i < DEPTH; i++) drive(1, 10 + i, 0, 0);
    idle(3);
    iREADY = 1'b1;
    for (int i = 0; i < 20; i++) drive(1, 40 + 7 * i, i, i % 3);
    idle(6);

    // Flush with two buffered and one in flight.
    iREADY = 1'b0;
    for (int i = 0; i < 3; i++) drive(1, 200 + i, 0, 0);
    idle(1);
    iCLR = 1'b1; cyc(); iCLR = 1'b0;
    iREADY = 1'b1;
    idle(10);

    // Asynchronous reset pulse mid-stream.
    iREADY = 1'b0;
    for (int i = 0; i < 3; i++) drive(1, 300 + i, 5, 1);
    idle(1);
    #1 iRSTn = 1'b0;
    #1 check_reset_outputs("async_rst");
    #1 iRSTn = 1'b1;
    iREADY = 1'b1;
    idle(10);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      iREADY = ($urandom_range(0, 9) < 7);
      iCLR   = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 3) != 0,
            int'($urandom_range(0, 1023)) - 512,
            int'($urandom_range(0, 1023)) - 512,
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(6, 15))
                                        : int'($urandom_range(0, 5)));
    end
    iCLR   = 1'b0;
    iREADY = 1'b1;
    idle(12);
    check("drain_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
